led_chaser_gen: RTL and testbench

LED_CHASER_GEN -- requirements
Module: led_chaser_gen

---
 rtl/led_chaser_gen.sv | 159 +++++++++++++++
 tb/tb_led_chaser_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser_gen.sv
// LED chaser: a WIN-wide lit window sweeps across N_LED outputs.
// Modes are loop, bounce, one-shot and hold. Steps are paced by a programmable prescaler.
module led_chaser_gen #(
    parameter int N_LED = 6,
    parameter int WIN   = 3,
    parameter int DIV_W = 24,
    localparam int PW   = $clog2(N_LED + WIN - 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic [N_LED-1:0] codeout,
    output logic [PW-1:0]    pos,
    output logic             step,
    output logic             done
);

    localparam int P_LAST = N_LED + WIN - 3;
    localparam logic [PW-1:0] P_LAST_V = PW'(P_LAST);
    localparam logic [PW-1:0] P_BACK_V = PW'(P_LAST - 1);
    localparam logic [1:0] M_LOOP   = 2'b00;
    localparam logic [1:0] M_BOUNCE = 2'b01;
    localparam logic [1:0] M_HOLD   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN_UP, S_RUN_DOWN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [N_LED-1:0] codeout_q, codeout_d;
    logic             step_q, step_d;
    logic             tick;
    logic             adv;

    // Lights pattern bit N_LED-1-k for each k in the window; mirroring lands it on bit k.
    function automatic logic [N_LED-1:0] window_bits(input logic [PW-1:0] p, input logic mirror);
        logic [N_LED-1:0] pat;
        int pi;
        pat = '0;
        pi  = int'(p);
        for (int k = 0; k < N_LED; k++) begin
            if (k <= pi && (pi - k) < WIN) begin
                if (mirror) pat[k] = 1'b1;
                else        pat[N_LED-1-k] = 1'b1;
            end
        end
        return pat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            cnt_q     <= '0;
            codeout_q <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            codeout_q <= codeout_d;
            step_q    <= step_d;
        end
    end

    // The prescaler also runs in DONE so that a switch to loop/bounce resumes on a tick.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        adv     = 1'b0;
        if (en && state_q != S_IDLE) begin
            if (cnt_q > div) begin
                cnt_d = '0;
            end else if (cnt_q == div) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_RUN_UP;
                    p_d     = '0;
                end
                S_RUN_UP: begin
                    if (tick && mode != M_HOLD) begin
                        if (p_q != P_LAST_V) begin
                            p_d = p_q + PW'(1);
                            adv = 1'b1;
                        end else if (mode == M_LOOP) begin
                            p_d = '0;
                            adv = 1'b1;
                        end else if (mode == M_BOUNCE) begin
                            state_d = S_RUN_DOWN;
                            p_d     = P_BACK_V;
                            adv     = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RUN_DOWN: begin
                    if (tick && mode != M_HOLD) begin
                        adv = 1'b1;
                        if (mode != M_BOUNCE) begin
                            state_d = S_RUN_UP;
                            p_d     = p_q + PW'(1);
                        end else if (p_q != '0) begin
                            p_d = p_q - PW'(1);
                        end else begin
                            state_d = S_RUN_UP;
                            p_d     = PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_RUN_UP;
                        p_d     = '0;
                        cnt_d   = '0;
                        adv     = 1'b1;
                    end else if (tick && mode == M_LOOP) begin
                        state_d = S_RUN_UP;
                        p_d     = '0;
                        adv     = 1'b1;
                    end else if (tick && mode == M_BOUNCE) begin
                        state_d = S_RUN_DOWN;
                        p_d     = P_BACK_V;
                        adv     = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        codeout_d = codeout_q;
        step_d    = 1'b0;
        if (en) begin
            codeout_d = (state_d == S_IDLE) ? '0 : window_bits(p_d, dir);
            step_d    = adv;
        end
        done = (state_q == S_DONE);
    end

    assign codeout = codeout_q;
    assign pos     = p_q;
    assign step    = step_q;

endmodule

// File: tb/tb_led_chaser_gen.sv
// Bench for led_chaser_gen: vector table, directed corner sequences and randomized run
// against a behavioural model of the window sweep.
module tb_led_chaser_gen;
  localparam int N_LED  = 6;
  localparam int WIN    = 3;
  localparam int DIV_W  = 24;
  localparam int PW     = 3;
  localparam int P_LAST = N_LED + WIN - 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             start;
  logic [DIV_W-1:0] div;
  logic [N_LED-1:0] codeout;
  logic [PW-1:0]    pos;
  logic             step;
  logic             done;

  led_chaser_gen #(.N_LED(N_LED), .WIN(WIN), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .start(start),
    .div(div), .codeout(codeout), .pos(pos), .step(step), .done(done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // behavioural model: phase 0 idle, 1 sweeping up, 2 sweeping down, 3 finished
  int               m_phase;
  int               m_p;
  int               m_cnt;
  logic [N_LED-1:0] m_code;
  logic             m_step;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window of WIN ones slides in from the top: shift it right by p+1 and keep N_LED bits.
  function automatic logic [N_LED-1:0] ref_pattern(input int p, input logic mir);
    longint w;
    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] out;
    w   = ((64'd1 << WIN) - 1) << N_LED;
    w   = w >> (p + 1);
    pat = w[N_LED-1:0];
    for (int i = 0; i < N_LED; i++) out[i] = mir ? pat[N_LED-1-i] : pat[i];
    return out;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_p     = 0;
    m_cnt   = 0;
    m_code  = '0;
    m_step  = 1'b0;
  endtask

  task automatic model_edge();
    int  old_p;
    bit  tk;
    bit  moved_up;
    if (!en) begin
      m_step = 1'b0;
      return;
    end
    if (m_phase == 0) begin
      m_phase = 1;
      m_p     = 0;
      m_step  = 1'b0;
      m_code  = ref_pattern(m_p, dir);
      return;
    end
    old_p = m_p;
    tk    = 1'b0;
    if (m_cnt > int'(div)) m_cnt = 0;
    else if (m_cnt == int'(div)) begin
      tk    = 1'b1;
      m_cnt = 0;
    end else m_cnt = m_cnt + 1;
    moved_up = (m_phase == 1 || m_phase == 3);
    if (m_phase == 3 && start) begin
      m_phase = 1;
      m_p     = 0;
      m_cnt   = 0;
    end else if (tk && mode != 2'b11) begin
      if (moved_up) begin
        if (m_phase == 1 && m_p < P_LAST) m_p = m_p + 1;
        else if (mode == 2'b00) begin
          m_p = 0; m_phase = 1;
        end else if (mode == 2'b01) begin
          m_p = P_LAST - 1; m_phase = 2;
        end else m_phase = 3;
      end else begin
        if (mode == 2'b01) begin
          if (m_p > 0) m_p = m_p - 1;
          else begin
            m_p = 1; m_phase = 1;
          end
        end else begin
          m_p = m_p + 1; m_phase = 1;
        end
      end
    end
    m_step = (m_p != old_p);
    m_code = ref_pattern(m_p, dir);
  endtask

  task automatic check_model();
    check("model_codeout", 32'(codeout), 32'(m_code));
    check("model_pos", 32'(pos), 32'(m_p));
    check("model_step", 32'(step), 32'(m_step));
    check("model_done", 32'(done), 32'(m_phase == 3));
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_codeout", 32'(codeout), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n = 0;
    while (int'(pos) != target && n < budget) begin
      cyc();
      n++;
    end
    check("reach_pos", 32'(pos), 32'(target));
  endtask

  typedef struct {
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic [N_LED-1:0] exp_code;
    int               exp_pos;
    logic             exp_step;
  } vec_t;

  vec_t tbl[8];
  int   bseq[13];

  initial begin
    tbl[0] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b100000, 0, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b110000, 1, 1'b1};
    tbl[2] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b111000, 2, 1'b1};
    tbl[3] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b011100, 3, 1'b1};
    tbl[4] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b001110, 4, 1'b1};
    tbl[5] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b000111, 5, 1'b1};
    tbl[6] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b000011, 6, 1'b1};
    tbl[7] = '{1'b1, 2'b00, 1'b0, 24'd0, 6'b100000, 0, 1'b1};
    bseq   = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};

    rst_n = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0; start = 1'b0; div = '0;
    model_reset();
    #2;
    apply_reset();

    // loop mode, div=0: table of consecutive edges
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; dir = tbl[i].dir; div = tbl[i].div;
      cyc();
      check("tbl_codeout", 32'(codeout), 32'(tbl[i].exp_code));
      check("tbl_pos", 32'(pos), 32'(tbl[i].exp_pos));
      check("tbl_step", 32'(step), 32'(tbl[i].exp_step));
    end

    // bounce: no endpoint repeated, then asynchronous reset at pos 5
    apply_reset();
    en = 1'b1; mode = 2'b01; div = '0;
    cyc();
    check("bounce_pos0", 32'(pos), 32'd0);
    for (int i = 0; i < 13; i++) begin
      cyc();
      check("bounce_pos", 32'(pos), 32'(bseq[i]));
    end
    repeat (4) cyc();
    check("bounce_at5", 32'(pos), 32'd5);
    apply_reset();
    cyc();
    check("post_rst_codeout", 32'(codeout), 32'(6'b100000));
    check("post_rst_pos", 32'(pos), 32'd0);

    // one-shot with div=2, then restart by start
    apply_reset();
    mode = 2'b10; div = 24'd2;
    cyc();
    for (int i = 0; i < 18; i++) begin
      cyc();
      check("oneshot_step", 32'(step), 32'(i % 3 == 2));
    end
    repeat (3) cyc();
    check("oneshot_done", 32'(done), 32'd1);
    check("oneshot_code", 32'(codeout), 32'(6'b000011));
    repeat (4) cyc();
    check("oneshot_hold_pos", 32'(pos), 32'd6);
    check("oneshot_hold_done", 32'(done), 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_pos", 32'(pos), 32'd0);
    check("restart_code", 32'(codeout), 32'(6'b100000));
    check("restart_done", 32'(done), 32'd0);

    // dir mirror at pos 2 with pos held by a slow prescaler
    apply_reset();
    mode = 2'b00; div = 24'd7;
    cyc();
    wait_pos(2, 100);
    dir = 1'b1;
    cyc();
    check("dir_code", 32'(codeout), 32'(6'b000111));
    check("dir_pos", 32'(pos), 32'd2);
    dir = 1'b0;

    // en low for 10 cycles at pos 3, resume from the held count
    apply_reset();
    div = 24'd4;
    cyc();
    wait_pos(3, 100);
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("freeze_code", 32'(codeout), 32'(6'b011100));
      check("freeze_step", 32'(step), 32'd0);
    end
    en = 1'b1;
    cyc();
    check("resume_step_a", 32'(step), 32'd0);
    cyc();
    check("resume_step_b", 32'(step), 32'd0);
    cyc();
    check("resume_step_c", 32'(step), 32'd1);
    check("resume_pos", 32'(pos), 32'd4);

    // randomized run against the model
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) dir = ~dir;
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 40) == 0) div = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 300) == 0) apply_reset();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
